// File: rtl/hazard_ctrl_n_if.sv
// Pipeline hazard controller signal bundle: stage waits, redirect/flush handshakes,
// per-register write controls and watchdog status.
interface hazard_ctrl_n_if #(
    parameter int NSTAGE = 4
);
    logic [NSTAGE-1:0]         wait_i;
    logic                      redirect_req;
    logic                      redirect_ack;
    logic                      flush_req;
    logic                      flush_ack;
    logic [2*(NSTAGE+1)-1:0]   reg_ctrl;
    logic                      is_stall;
    logic                      stall_timeout;
    logic                      timeout_clr;

    // Handshakes: redirect_req is a level held until redirect_ack is seen in the same cycle;
    // flush_req is a one-cycle pulse, acknowledged by flush_ack when the full flush is applied.
    modport master (
        output wait_i, redirect_req, flush_req, timeout_clr,
        input  redirect_ack, flush_ack, reg_ctrl, is_stall, stall_timeout
    );

    modport slave (
        input  wait_i, redirect_req, flush_req, timeout_clr,
        output redirect_ack, flush_ack, reg_ctrl, is_stall, stall_timeout
    );
endinterface

// File: rtl/hazard_ctrl_n.sv
// Pipeline hazard controller: per-register stream/bubble/keep controls, deferred flush
// that waits out non-abortable bus transactions, redirect handshake and stall watchdog.
module hazard_ctrl_n #(
    parameter int                NSTAGE     = 4,
    parameter logic [NSTAGE-1:0] ABORT_MASK = 4'b0110,
    parameter int                RDEPTH     = 1,
    parameter int                WDOG_LIMIT = 255,
    localparam int               CW         = $clog2(WDOG_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    hazard_ctrl_n_if.slave      bus,
    output logic                state_dbg_o,
    output logic [CW-1:0]       stall_cnt_dbg_o
);
    localparam int RW = 2 * (NSTAGE + 1);
    localparam logic [RW-1:0] CTRL_FLUSH = {{NSTAGE{2'b01}}, 2'b00};
    localparam logic [RW-1:0] CTRL_HOLD  = '1;
    localparam logic [RW-1:0] CTRL_RESET = {(NSTAGE + 1){2'b01}};
    localparam logic [CW-1:0] LIMIT      = CW'(WDOG_LIMIT);

    typedef enum logic {RUN = 1'b0, FLUSH_WAIT = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            stall_timeout_q, stall_timeout_d;

    logic [RW-1:0]   ctrl_c;
    logic            rack_c, fack_c, stall_c;
    logic            nonabort;
    int              deepest;

    assign nonabort = |(bus.wait_i & ~ABORT_MASK);

    always_comb begin
        state_d = state_q;
        ctrl_c  = '0;
        rack_c  = 1'b0;
        fack_c  = 1'b0;
        stall_c = 1'b0;
        deepest = 0;
        for (int i = 1; i <= NSTAGE; i++) begin
            if (bus.wait_i[i-1]) deepest = i;
        end
        case (state_q)
            RUN: begin
                if (bus.flush_req && !nonabort) begin
                    ctrl_c = CTRL_FLUSH;
                    fack_c = 1'b1;
                end else if (bus.flush_req) begin
                    ctrl_c  = CTRL_HOLD;
                    stall_c = 1'b1;
                    state_d = FLUSH_WAIT;
                end else if (deepest != 0) begin
                    // Bubble the deepest busy stage, freeze everything behind it, drain ahead.
                    for (int j = 0; j <= NSTAGE; j++) begin
                        if (j < deepest)       ctrl_c[2*j +: 2] = 2'b11;
                        else if (j == deepest) ctrl_c[2*j +: 2] = 2'b01;
                        else                   ctrl_c[2*j +: 2] = 2'b00;
                    end
                end else if (bus.redirect_req) begin
                    for (int j = 1; j <= RDEPTH; j++) ctrl_c[2*j +: 2] = 2'b01;
                    rack_c = 1'b1;
                end
            end
            FLUSH_WAIT: begin
                // Pending redirect is never acked here; its source gets flushed anyway.
                if (nonabort) begin
                    ctrl_c  = CTRL_HOLD;
                    stall_c = 1'b1;
                end else begin
                    ctrl_c  = CTRL_FLUSH;
                    fack_c  = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d     = '0;
        stall_timeout_d = stall_timeout_q;
        if (ctrl_c[1:0] == 2'b11) begin
            stall_cnt_d = (stall_cnt_q == LIMIT) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end
        // A set on the same edge as a clear request wins.
        if (ctrl_c[1:0] == 2'b11 && stall_cnt_q != LIMIT && stall_cnt_d == LIMIT) begin
            stall_timeout_d = 1'b1;
        end else if (bus.timeout_clr) begin
            stall_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= RUN;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign bus.reg_ctrl      = resetn ? ctrl_c  : CTRL_RESET;
    assign bus.redirect_ack  = resetn & rack_c;
    assign bus.flush_ack     = resetn & fack_c;
    assign bus.is_stall      = resetn & stall_c;
    assign bus.stall_timeout = stall_timeout_q;

    assign state_dbg_o     = state_q;
    assign stall_cnt_dbg_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_n.sv
// Directed bench for hazard_ctrl_n: combinational vector table plus hand-written
// deferred flush, redirect, watchdog and reset sequences.
module tb_hazard_ctrl_n;
    localparam int N = 4;

    logic clk;
    logic resetn;
    logic state_a, state_b;
    logic [3:0] cnt_a, cnt_b;

    hazard_ctrl_n_if #(.NSTAGE(N)) bus_a ();
    hazard_ctrl_n_if #(.NSTAGE(N)) bus_b ();

    hazard_ctrl_n #(.NSTAGE(N), .ABORT_MASK(4'b0110), .RDEPTH(1), .WDOG_LIMIT(8)) dut (
        .clk(clk), .resetn(resetn), .bus(bus_a),
        .state_dbg_o(state_a), .stall_cnt_dbg_o(cnt_a)
    );

    hazard_ctrl_n #(.NSTAGE(N), .ABORT_MASK(4'b0110), .RDEPTH(2), .WDOG_LIMIT(8)) dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b),
        .state_dbg_o(state_b), .stall_cnt_dbg_o(cnt_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] w;
        logic       rr;
        logic       fr;
        logic [9:0] ctrl;
        logic       rack;
        logic       fack;
        logic       stall;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic [3:0] w, input logic rr, input logic fr, input logic tc);
        bus_a.wait_i = w; bus_a.redirect_req = rr; bus_a.flush_req = fr; bus_a.timeout_clr = tc;
        bus_b.wait_i = w; bus_b.redirect_req = rr; bus_b.flush_req = fr; bus_b.timeout_clr = tc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [9:0] ctrl, input logic rack,
                           input logic fack, input logic stall);
        chk({name, ".ctrl"},  32'(bus_a.reg_ctrl),     32'(ctrl));
        chk({name, ".rack"},  32'(bus_a.redirect_ack), 32'(rack));
        chk({name, ".fack"},  32'(bus_a.flush_ack),    32'(fack));
        chk({name, ".stall"}, 32'(bus_a.is_stall),     32'(stall));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk_out("reset", 10'b01_01_01_01_01, 1'b0, 1'b0, 1'b0);
        chk("reset.timeout", 32'(bus_a.stall_timeout), 32'd0);
        chk("reset.cnt", 32'(cnt_a), 32'd0);
        chk("reset.state", 32'(state_a), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        vecs[0] = '{4'b0000, 1'b0, 1'b0, 10'b00_00_00_00_00, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b0100, 1'b0, 1'b0, 10'b00_01_11_11_11, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'b1010, 1'b1, 1'b0, 10'b01_11_11_11_11, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'b0000, 1'b1, 1'b0, 10'b00_00_00_01_00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{4'b0100, 1'b0, 1'b1, 10'b01_01_01_01_00, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{4'b0001, 1'b0, 1'b0, 10'b00_00_00_01_11, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'b0001, 1'b1, 1'b0, 10'b00_00_00_01_11, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{4'b0010, 1'b0, 1'b0, 10'b00_00_01_11_11, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{4'b0110, 1'b1, 1'b1, 10'b01_01_01_01_00, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{4'b1000, 1'b0, 1'b0, 10'b01_11_11_11_11, 1'b0, 1'b0, 1'b0};

        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Table of single-cycle behaviours in RUN
        for (int v = 0; v < 10; v++) begin
            tick();
            drv(vecs[v].w, vecs[v].rr, vecs[v].fr, 1'b0);
            @(negedge clk);
            chk_out($sformatf("vec%0d", v), vecs[v].ctrl, vecs[v].rack, vecs[v].fack, vecs[v].stall);
            chk($sformatf("vec%0d.state", v), 32'(state_a), 32'd0);
        end

        // Deferred flush behind a dmem wait; second flush_req and a redirect are ignored
        tick(); drv(4'b1000, 1'b0, 1'b1, 1'b0);
        @(negedge clk); chk_out("dfl.c1", 10'h3FF, 1'b0, 1'b0, 1'b1);
        tick(); drv(4'b1000, 1'b0, 1'b1, 1'b0);
        @(negedge clk); chk_out("dfl.c2", 10'h3FF, 1'b0, 1'b0, 1'b1);
        chk("dfl.c2.state", 32'(state_a), 32'd1);
        tick(); drv(4'b1000, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk_out("dfl.c3", 10'h3FF, 1'b0, 1'b0, 1'b1);
        tick(); drv(4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk_out("dfl.c4", 10'b01_01_01_01_00, 1'b0, 1'b1, 1'b0);
        tick(); drv(4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk_out("dfl.c5", 10'b00_00_00_00_00, 1'b0, 1'b0, 1'b0);
        chk("dfl.c5.state", 32'(state_a), 32'd0);

        // Minimum residency: wait drops right after entry
        tick(); drv(4'b0001, 1'b0, 1'b1, 1'b0);
        @(negedge clk); chk_out("min.c1", 10'h3FF, 1'b0, 1'b0, 1'b1);
        tick(); drv(4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk_out("min.c2", 10'b01_01_01_01_00, 1'b0, 1'b1, 1'b0);

        // Redirect held behind imem wait, RDEPTH 1 and 2
        for (int c = 0; c < 2; c++) begin
            tick(); drv(4'b0001, 1'b1, 1'b0, 1'b0);
            @(negedge clk); chk_out($sformatf("rdr.w%0d", c), 10'b00_00_00_01_11, 1'b0, 1'b0, 1'b0);
        end
        tick(); drv(4'b0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("rdr.go", 10'b00_00_00_01_00, 1'b1, 1'b0, 1'b0);
        chk("rdr.b.ctrl", 32'(bus_b.reg_ctrl), 32'(10'b00_00_01_01_00));
        chk("rdr.b.rack", 32'(bus_b.redirect_ack), 32'd1);
        tick(); drv(4'b0000, 1'b0, 1'b0, 1'b0);

        // Watchdog
        do_reset();
        drv(4'b1000, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 7) chk("wd.e7.timeout", 32'(bus_a.stall_timeout), 32'd0);
            if (c == 8) chk("wd.e8.timeout", 32'(bus_a.stall_timeout), 32'd1);
            if (c == 8) chk("wd.e8.cnt", 32'(cnt_a), 32'd8);
            if (c == 10) chk("wd.e10.cnt", 32'(cnt_a), 32'd8);
        end
        chk("wd.hold.timeout", 32'(bus_a.stall_timeout), 32'd1);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("wd.sticky", 32'(bus_a.stall_timeout), 32'd1);
        chk("wd.cnt_clear", 32'(cnt_a), 32'd0);
        drv(4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        chk("wd.clr", 32'(bus_a.stall_timeout), 32'd0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);

        // Reset in FLUSH_WAIT discards the pending flush
        tick(); drv(4'b1000, 1'b0, 1'b1, 1'b0);
        tick(); drv(4'b1000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rfw.state", 32'(state_a), 32'd1);
        resetn = 1'b0;
        #1;
        chk_out("rfw.inreset", 10'b01_01_01_01_01, 1'b0, 1'b0, 1'b0);
        tick();
        resetn = 1'b1;
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rfw.post.state", 32'(state_a), 32'd0);
        chk("rfw.post.cnt", 32'(cnt_a), 32'd0);
        chk_out("rfw.post", 10'b00_00_00_00_00, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected done");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/hazard_ctrl_n.md
# hazard_ctrl_n

Parametrised pipeline hazard controller for an N-register in-order pipeline: PC register R0 plus pipeline registers R1..RN, nominally F/D/E/M for N=4. Each cycle it produces a 2-bit write control per register from per-stage wait signals, a branch/jump redirect request and a trap/CSR flush request. Unlike the single-cycle combinational predecessor it has:
- a deferred-flush state machine that waits for non-abortable bus transactions before flushing;
- redirect and flush request/acknowledge handshakes;
- a stall watchdog.

## Interface
- NSTAGE, 4: number of pipeline registers after the PC (R1..RN).
- ABORT_MASK, 4'b0110: NSTAGE bits. Bit i-1 set means wait[i] may be abandoned by a flush.
- RDEPTH, 1: a redirect flushes R1..R[RDEPTH]. Legal range 1..NSTAGE.
- WDOG_LIMIT, 255: consecutive PC-hold cycles before timeout. Must be ≥1.
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- wait_i  in  NSTAGE  bit i-1 = wait[i]: the stage feeding Ri is busy. wait[1] is imem, wait[NSTAGE] is dmem.
- redirect_req  in  1  level request to load a new PC; held until acknowledged.
- redirect_ack  out  1  redirect applied this cycle.
- flush_req  in  1  single-cycle pulse from commit (trap/CSR).
- flush_ack  out  1  full flush applied this cycle.
- reg_ctrl  out  2*(NSTAGE+1)  bits [2i+1:2i] control Ri. Encodings: 00 = stream, 01 = flush/bubble, 11 = keep. 10 is never driven.
- is_stall  out  1  pipeline frozen awaiting a deferred flush.
- stall_timeout  out  1  sticky watchdog flag.
- timeout_clr  in  1  clears stall_timeout.

## Operation
- Terminology: "nonabort wait" = any wait[i] with ABORT_MASK[i-1]=0.
- FSM states: RUN and FLUSH_WAIT.
- Register k is "deepest" if wait[k]=1 and wait[j]=0 for all j>k.

RUN, first match wins:
1. flush_req=1 and no nonabort wait:
   - R1..RN=01, R0=00, flush_ack=1.
   - Abortable waits are ignored this cycle.
2. flush_req=1 and a nonabort wait is present:
   - Go to FLUSH_WAIT.
   - This cycle: all Ri=11, is_stall=1.
3. Any wait[i]=1, with k the deepest:
   - Rk=01, R0..R(k-1)=11, R(k+1)..RN=00.
   - redirect_ack=0.
4. redirect_req=1:
   - R1..R[RDEPTH]=01, R0=00, remaining registers 00.
   - redirect_ack=1.
5. Otherwise all 00.

FLUSH_WAIT:
- While any nonabort wait is high: all 11, is_stall=1, flush_ack=0.
- First cycle with no nonabort wait: apply the step-1 flush, flush_ack=1, is_stall=0, next state RUN.
- flush_req in this state is ignored (a flush is already pending).
- redirect_req is never acknowledged here. The flush supersedes it, and its source is flushed.

Watchdog:
- stall_cnt is $clog2(WDOG_LIMIT+1) bits.
- Increments on each cycle with R0=11. Saturates at WDOG_LIMIT.
- Cleared to 0 on any cycle with R0≠11.
- stall_timeout sets on the edge where stall_cnt transitions to WDOG_LIMIT. It stays set until timeout_clr or reset.
- If timeout_clr and a set condition occur together, set wins.

## Timing
- reg_ctrl, redirect_ack, flush_ack and is_stall are combinational from inputs and state: zero-cycle latency. They must not depend combinationally on timeout_clr.
- FSM state, stall_cnt and stall_timeout are registered on posedge clk.
- Asynchronous reset while resetn=0:
  - state RUN, stall_cnt 0, stall_timeout 0.
  - reg_ctrl all 01, redirect_ack 0, flush_ack 0, is_stall 0.
- Reset in FLUSH_WAIT discards the pending flush.
- flush_ack and redirect_ack are never both 1 in the same cycle.
- Minimum FLUSH_WAIT residency: 1 cycle beyond the entering cycle if the nonabort wait drops immediately. The flush occurs the cycle after entry.
- NSTAGE=1 is legal: R1 only, and ABORT_MASK is 1 bit.

## Test plan
- NSTAGE=4, wait_i=4'b0100 (wait[3]) -> reg_ctrl = R4:00 R3:01 R2:11 R1:11 R0:11, i.e. 10'b00_01_11_11_11.
- wait_i=4'b1010 (wait[2], wait[4]) -> deepest is 4: R4=01, R3..R0=11. Add redirect_req=1 -> redirect_ack=0.
- flush_req pulse with wait_i=4'b0100 (abortable) -> same cycle: R1..R4=01, R0=00, flush_ack=1. State stays RUN.
- flush_req pulse with wait[4] high for 3 cycles -> 3 cycles of all-11 with is_stall=1. Cycle 4 (wait low): R1..R4=01, R0=00, flush_ack=1. Cycle 5: RUN, all 00. A second flush_req on cycle 2 produces no extra ack.
- redirect_req held with wait[1] high for 2 cycles -> R1=01, R0=11, ack=0. When wait drops: R1=01, R0=00, redirect_ack=1. With RDEPTH=2, R2=01 also.
- WDOG_LIMIT=8, wait[4] held 10 cycles -> stall_timeout rises after the 8th clock edge and stays high. timeout_clr pulse -> low. Assert resetn=0 mid-FLUSH_WAIT -> outputs all 01, and after release state is RUN with stall_cnt=0.
